// File: rtl/scaler_bank_v3.sv
// Bank of NCH saturating edge counters gated by an internal period or the TURF
// reference pulse. A gate end latches the counts into a readable bank and clears them.

module scaler_lane #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          edge_i,
  input  logic          gate_end_i,
  output logic [CW-1:0] bank_o,
  output logic          ovf_o
);
  logic [CW-1:0] cnt_q, cnt_d, bank_q, bank_d;
  logic          run_ovf_q, run_ovf_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_inc;
  logic          ovf_inc;
  logic          sat;

  always_comb begin
    sat       = &cnt_q;
    cnt_inc   = (edge_i && !sat) ? cnt_q + 1'b1 : cnt_q;
    ovf_inc   = run_ovf_q | (edge_i & sat);
    cnt_d     = cnt_inc;
    run_ovf_d = ovf_inc;
    bank_d    = bank_q;
    ovf_d     = ovf_q;
    // The edge seen on a gate-end cycle belongs to the closing interval.
    if (gate_end_i) begin
      bank_d    = cnt_inc;
      ovf_d     = ovf_inc;
      cnt_d     = '0;
      run_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      run_ovf_q <= 1'b0;
      bank_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_ovf_q <= run_ovf_d;
      bank_q    <= bank_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bank_o = bank_q;
  assign ovf_o  = ovf_q;
endmodule

module scaler_bank_v3 #(
  parameter int NCH    = 17,
  parameter int CW     = 16,
  parameter int AW     = 5,
  parameter int PERIOD = 33333333
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] scal_i,
  input  logic           ref_i,
  input  logic           mode_i,
  input  logic [AW-1:0]  scal_addr_i,
  input  logic           scal_rd_i,
  output logic [CW-1:0]  scal_dat_o,
  output logic           scal_valid_o,
  output logic [NCH-1:0] ovf_o,
  output logic           update_o,
  output logic [15:0]    refpulse_cnt_o
);
  localparam int PW = $clog2(PERIOD + 1);

  logic [NCH-1:0]         scal_prev_q, scal_prev_d;
  logic                   ref_prev_q, ref_prev_d;
  logic                   mode_q, mode_d;
  logic [PW-1:0]          per_q, per_d;
  logic                   update_q, update_d;
  logic [15:0]            refcnt_q, refcnt_d;
  logic [CW-1:0]          dat_q, dat_d;
  logic                   valid_q, valid_d;
  logic [NCH-1:0]         scal_edge;
  logic                   ref_edge;
  logic                   gate_end;
  logic [NCH-1:0][CW-1:0] bank;
  logic [CW-1:0]          rd_dat;

  always_comb begin
    scal_edge   = scal_i & ~scal_prev_q;
    ref_edge    = ref_i & ~ref_prev_q;
    gate_end    = mode_i ? ref_edge : (per_q == PW'(PERIOD - 1));
    scal_prev_d = scal_i;
    ref_prev_d  = ref_i;
    mode_d      = mode_i;
    // Period counter idles at 0 in ref mode and restarts on any mode change.
    if (mode_i || (mode_i != mode_q) || gate_end) per_d = '0;
    else                                          per_d = per_q + 1'b1;
    update_d = gate_end;
    refcnt_d = ref_edge ? refcnt_q + 16'd1 : refcnt_q;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    scaler_lane #(.CW(CW)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .edge_i     (scal_edge[n]),
      .gate_end_i (gate_end),
      .bank_o     (bank[n]),
      .ovf_o      (ovf_o[n])
    );
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NCH; i++)
      if (scal_addr_i == AW'(i)) rd_dat = bank[i];
    dat_d   = scal_rd_i ? rd_dat : dat_q;
    valid_d = scal_rd_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scal_prev_q <= '0;
      ref_prev_q  <= 1'b0;
      mode_q      <= 1'b0;
      per_q       <= '0;
      update_q    <= 1'b0;
      refcnt_q    <= '0;
      dat_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      scal_prev_q <= scal_prev_d;
      ref_prev_q  <= ref_prev_d;
      mode_q      <= mode_d;
      per_q       <= per_d;
      update_q    <= update_d;
      refcnt_q    <= refcnt_d;
      dat_q       <= dat_d;
      valid_q     <= valid_d;
    end
  end

  assign scal_dat_o     = dat_q;
  assign scal_valid_o   = valid_q;
  assign update_o       = update_q;
  assign refpulse_cnt_o = refcnt_q;
endmodule

// File: tb/tb_scaler_bank_v3.sv
// Directed bench for scaler_bank_v3: a 16-bit and a 4-bit instance share stimulus;
// read responses are checked by scoreboard monitors, gate/flag outputs inline.

module tb_scaler_bank_v3;
  localparam int NCH = 17;
  localparam int AW  = 5;
  localparam int PER = 100;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [NCH-1:0] scal_i;
  logic           ref_i, mode_i, scal_rd_i;
  logic [AW-1:0]  scal_addr_i;

  logic [15:0]    dat_a, rcnt_a, rcnt_b;
  logic [3:0]     dat_b;
  logic           valid_a, valid_b, upd_a, upd_b;
  logic [NCH-1:0] ovf_a, ovf_b;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always #5 clk = ~clk;

  scaler_bank_v3 #(.NCH(NCH), .CW(16), .AW(AW), .PERIOD(PER)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .scal_i(scal_i), .ref_i(ref_i), .mode_i(mode_i),
    .scal_addr_i(scal_addr_i), .scal_rd_i(scal_rd_i), .scal_dat_o(dat_a),
    .scal_valid_o(valid_a), .ovf_o(ovf_a), .update_o(upd_a), .refpulse_cnt_o(rcnt_a));

  scaler_bank_v3 #(.NCH(NCH), .CW(4), .AW(AW), .PERIOD(PER)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .scal_i(scal_i), .ref_i(ref_i), .mode_i(mode_i),
    .scal_addr_i(scal_addr_i), .scal_rd_i(scal_rd_i), .scal_dat_o(dat_b),
    .scal_valid_o(valid_b), .ovf_o(ovf_b), .update_o(upd_b), .refpulse_cnt_o(rcnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles since reset release, as seen at the falling edge.
  initial forever begin
    @(posedge clk);
    if (rst_i) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Scoreboard monitor, 16-bit instance; also checks hold of data between reads.
  initial begin
    logic [15:0] last, e;
    last = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) last = '0;
      else if (valid_a) begin
        if (exp_a.size() == 0) chk("rd_a_unexpected", 32'(dat_a), 32'hFFFF_FFFF);
        else begin
          e = exp_a.pop_front();
          chk("rd_a", 32'(dat_a), 32'(e));
        end
        last = dat_a;
      end else chk("hold_a", 32'(dat_a), 32'(last));
    end
  end

  // Scoreboard monitor, 4-bit saturating instance.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk); #1;
      if (!rst_i && valid_b) begin
        if (exp_b.size() == 0) chk("rd_b_unexpected", 32'(dat_b), 32'hFFFF_FFFF);
        else begin
          e = exp_b.pop_front();
          chk("rd_b", 32'(dat_b), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input int ch);
    scal_i[ch] = 1'b1; tick();
    scal_i[ch] = 1'b0; tick();
  endtask

  task automatic rd(input int addr, input int ea, input int eb);
    scal_addr_i = AW'(addr);
    scal_rd_i   = 1'b1;
    exp_a.push_back(16'(ea));
    exp_b.push_back(16'(eb));
    tick();
    scal_rd_i   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      tick();
      guard++;
    end
    chk("wait_cyc_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic chk_upd(input string name, input logic v);
    chk({name, "_a"}, 32'(upd_a), 32'(v));
    chk({name, "_b"}, 32'(upd_b), 32'(v));
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_dat"},   32'(dat_a),   0);
    chk({name, "_valid"}, 32'(valid_a), 0);
    chk({name, "_ovf"},   32'(ovf_b),   0);
    chk({name, "_upd"},   32'(upd_a),   0);
    chk({name, "_rcnt"},  32'(rcnt_a),  0);
    chk({name, "_rcntb"}, 32'(rcnt_b),  0);
  endtask

  initial begin
    int mark;
    rst_i = 1'b1; scal_i = '0; ref_i = 1'b0; mode_i = 1'b0;
    scal_rd_i = 1'b0; scal_addr_i = '0;
    repeat (3) tick();
    chk_zero_outs("reset");
    rst_i = 1'b0;

    // Internal gate: 10 pulses on ch3, plus a ch0 edge on the gate-end cycle.
    repeat (10) pulse(3);
    wait_cyc(PER - 1);
    chk_upd("upd_before_gate", 1'b0);
    scal_i[0] = 1'b1;
    rd(3, 0, 0);
    chk_upd("upd_gate1", 1'b1);
    scal_i[0] = 1'b0;
    rd(3, 10, 10);
    chk_upd("upd_one_cycle", 1'b0);
    rd(0, 1, 1);

    // Saturation: 20 edges on ch1 saturate the 4-bit instance.
    repeat (20) pulse(1);
    wait_cyc(2 * PER - 1);
    rd(3, 10, 10);
    chk_upd("upd_gate2", 1'b1);
    chk("ovf_a_gate2", 32'(ovf_a), 0);
    chk("ovf_b_gate2", 32'(ovf_b), 32'h2);
    rd(1, 20, 15);
    rd(0, 0, 0);
    rd(20, 0, 0);
    rd(3, 0, 0);

    // Next interval with 2 edges clears the overflow flag.
    repeat (2) pulse(1);
    wait_cyc(3 * PER - 1);
    rd(1, 20, 15);
    chk_upd("upd_gate3", 1'b1);
    chk("ovf_b_gate3", 32'(ovf_b), 0);
    rd(1, 2, 2);

    // Ref mode: counts on ch2 survive the mode switch, no internal gate fires.
    repeat (3) pulse(2);
    mode_i = 1'b1;
    repeat (95) tick();
    chk_upd("upd_ref_idle", 1'b0);
    ref_i = 1'b1; tick();
    chk_upd("upd_ref1", 1'b1);
    chk("rcnt_ref1", 32'(rcnt_a), 1);
    ref_i = 1'b0;
    mark = cyc;
    rd(2, 3, 3);
    rd(16, 0, 0);
    repeat (5) pulse(16);
    wait_cyc(mark + 49);
    chk_upd("upd_ref_wait", 1'b0);
    ref_i = 1'b1; tick();
    chk_upd("upd_ref2", 1'b1);
    chk("rcnt_ref2_a", 32'(rcnt_a), 2);
    chk("rcnt_ref2_b", 32'(rcnt_b), 2);
    ref_i = 1'b0;
    rd(16, 5, 5);
    chk("ovf_a_ref", 32'(ovf_a), 0);

    // Mid-interval reset: partial ch5 counts are dropped; ch7 high across release counts once.
    mode_i = 1'b0; tick();
    repeat (3) pulse(5);
    scal_i[7] = 1'b1; tick();
    rst_i = 1'b1; tick();
    chk_zero_outs("midreset");
    rst_i = 1'b0; tick();
    scal_i[7] = 1'b0;
    wait_cyc(PER - 1);
    chk_upd("upd_post_rst_pre", 1'b0);
    tick();
    chk_upd("upd_post_rst", 1'b1);
    rd(5, 0, 0);
    rd(7, 1, 1);
    rd(16, 0, 0);
    repeat (3) tick();
    chk("sb_a_drained", 32'(exp_a.size()), 0);
    chk("sb_b_drained", 32'(exp_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
